// File: rtl/snake_pkg.sv
// Shared types for the snake game: direction encoding, FSM states and
// helpers used by the direction-input front end.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PRESENT = 2'd2
  } fsm_t;

  localparam int NUM_BTNS = 4;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  function automatic logic [NUM_BTNS-1:0] dir_onehot(input dir_t d);
    return NUM_BTNS'(1) << d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: synchroniser, stability counter and a
// single-cycle press pulse on each accepted 0->1 of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   synced_prev;
  logic [CW-1:0]          cnt;
  logic                   level;

  assign synced = sync[SYNC_STAGES-1];

  // Counter restarts on every synchronised edge and saturates once the
  // input has been stable long enough, so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= '0;
      synced_prev <= 1'b0;
      cnt         <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
    end else begin
      sync        <= SYNC_STAGES'({sync, raw});
      synced_prev <= synced;
      press       <= 1'b0;
      if (synced != synced_prev) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (synced == synced_prev && cnt == CNT_MAX && level != synced) begin
        level <= synced;
        press <= synced;
      end
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// Turns four bouncing direction buttons into one-hot direction requests
// presented to the snake game during its sampling window.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       is_listening,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] cur_dir,
  output logic       pending_valid
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press_vec;
  logic [NUM_BTNS-1:0] onehot;
  fsm_t                state;
  dir_t                cur_q;
  dir_t                pending_dir;
  dir_t                sel;
  dir_t                dir_ref;
  logic                enter_present;
  logic                accept;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_btn (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .press(press_vec[i])
    );
  end

  // A press coinciding with the window opening is judged against the
  // direction that is being committed on that same edge.
  always_comb begin
    sel = RIGHT;
    if (press_vec[0])      sel = UP;
    else if (press_vec[1]) sel = DOWN;
    else if (press_vec[2]) sel = LEFT;
    enter_present = (state == ARMED) && is_listening;
    dir_ref       = enter_present ? pending_dir : cur_q;
    accept        = (|press_vec) && (sel != dir_ref) && (sel != opposite(dir_ref));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_q         <= RIGHT;
      pending_dir   <= RIGHT;
      pending_valid <= 1'b0;
      onehot        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_valid) state <= ARMED;
        end
        ARMED: begin
          if (is_listening) begin
            state  <= PRESENT;
            cur_q  <= pending_dir;
            onehot <= dir_onehot(pending_dir);
          end
        end
        PRESENT: begin
          if (!is_listening) begin
            state  <= IDLE;
            onehot <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        pending_dir   <= sel;
        pending_valid <= 1'b1;
      end else if (enter_present) begin
        pending_valid <= 1'b0;
      end
    end
  end

  assign {right, left, down, up} = onehot;
  assign cur_dir = cur_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Self-checking bench for snake_dir_input: directed scenarios followed by
// random press/release/window steps, all checked against an event-level model.
module tb_snake_dir_input;

  localparam int DB   = 250;
  localparam int HOLD = DB + 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = '0;
  logic       is_listening = 1'b0;
  logic       up, down, left, right;
  logic [1:0] cur_dir;
  logic       pending_valid;

  int tests = 0;
  int fails = 0;

  // Reference model: committed direction, stored press, buttons held down.
  int         m_cur  = 3;
  bit         m_pv   = 1'b0;
  int         m_pd   = 3;
  logic [3:0] m_held = '0;

  snake_dir_input #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (2)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn[0]),
    .btn_down     (btn[1]),
    .btn_left     (btn[2]),
    .btn_right    (btn[3]),
    .is_listening (is_listening),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .cur_dir      (cur_dir),
    .pending_valid(pending_valid)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_onehot();
    return {28'd0, right, left, down, up};
  endfunction

  task automatic check_quiet(input string tag);
    check_output({tag, "_outs"}, obs_onehot(), 32'd0);
    check_output({tag, "_cur"}, {30'd0, cur_dir}, m_cur);
    check_output({tag, "_pv"}, {31'd0, pending_valid}, {31'd0, m_pv});
  endtask

  // Newly pressed buttons resolve by priority up>down>left>right, then the
  // winner is kept unless it repeats or reverses the committed direction.
  task automatic model_press(input logic [3:0] mask);
    logic [3:0] fresh;
    fresh  = mask & ~m_held;
    m_held = m_held | mask;
    for (int i = 0; i < 4; i++) begin
      if (fresh[i]) begin
        if (i != m_cur && i != (m_cur ^ 1)) begin
          m_pd = i;
          m_pv = 1'b1;
        end
        break;
      end
    end
  endtask

  task automatic apply_stimulus_press(input logic [3:0] mask, input int glitches, input string tag);
    for (int g = 0; g < glitches; g++) begin
      btn = btn | mask;
      wait_cycles($urandom_range(1, 4));
      btn = btn & ~mask;
      wait_cycles($urandom_range(1, 3));
    end
    btn = btn | mask;
    wait_cycles(HOLD);
    model_press(mask);
    check_quiet(tag);
  endtask

  task automatic apply_stimulus_release(input logic [3:0] mask, input string tag);
    btn = btn & ~mask;
    wait_cycles(HOLD);
    m_held = m_held & ~mask;
    check_quiet(tag);
  endtask

  task automatic apply_stimulus_window(input int len, input string tag);
    logic [31:0] exp_oh;
    exp_oh = 32'd0;
    if (m_pv) begin
      m_cur  = m_pd;
      m_pv   = 1'b0;
      exp_oh = 32'd1 << m_cur;
    end
    is_listening = 1'b1;
    wait_cycles(3);
    check_output({tag, "_win_start"}, obs_onehot(), exp_oh);
    wait_cycles(len - 3);
    check_output({tag, "_win_end"}, obs_onehot(), exp_oh);
    check_output({tag, "_win_cur"}, {30'd0, cur_dir}, m_cur);
    is_listening = 1'b0;
    wait_cycles(3);
    check_quiet({tag, "_after"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst    = 1'b0;
    m_cur  = 3;
    m_pd   = 3;
    m_pv   = 1'b0;
    m_held = '0;
  endtask

  initial begin
    logic [3:0] mask;
    int         action;

    btn = '0;
    do_reset();
    check_quiet("reset");

    // A press shorter than the debounce period never registers.
    btn[0] = 1'b1;
    wait_cycles(100);
    btn[0] = 1'b0;
    wait_cycles(HOLD);
    check_quiet("short_pulse");

    // Bouncy but long press of up, then presented in a 50-cycle window.
    apply_stimulus_press(4'b0001, 5, "bouncy_up");
    apply_stimulus_release(4'b0001, "rel_up");
    apply_stimulus_window(50, "present_up");

    // Get to RIGHT, then a reversal (left) is rejected and down accepted.
    apply_stimulus_press(4'b1000, 0, "to_right");
    apply_stimulus_release(4'b1000, "rel_right");
    apply_stimulus_window(8, "present_right");
    apply_stimulus_press(4'b0100, 2, "reverse_left");
    apply_stimulus_release(4'b0100, "rel_left");
    apply_stimulus_press(4'b0010, 0, "accept_down");
    apply_stimulus_release(4'b0010, "rel_down");
    apply_stimulus_window(10, "present_down");

    // From RIGHT: up accepted, following left is a reversal and is dropped.
    apply_stimulus_press(4'b1000, 0, "to_right2");
    apply_stimulus_release(4'b1000, "rel_right2");
    apply_stimulus_window(6, "present_right2");
    apply_stimulus_press(4'b0001, 0, "seq_up");
    apply_stimulus_release(4'b0001, "rel_seq_up");
    apply_stimulus_press(4'b0100, 0, "seq_left");
    apply_stimulus_release(4'b0100, "rel_seq_left");
    apply_stimulus_window(6, "present_seq");

    // From UP: left then right, the last accepted press wins.
    apply_stimulus_press(4'b0100, 0, "lw_left");
    apply_stimulus_release(4'b0100, "rel_lw_left");
    apply_stimulus_press(4'b1000, 0, "lw_right");
    apply_stimulus_release(4'b1000, "rel_lw_right");
    apply_stimulus_window(6, "present_lw");

    // Up and left debounced together: priority keeps up.
    apply_stimulus_press(4'b0101, 0, "same_cycle");
    apply_stimulus_release(4'b0101, "rel_same_cycle");
    apply_stimulus_window(6, "present_same");

    // Reset in the middle of presenting right, with up held through it.
    apply_stimulus_press(4'b1000, 0, "pre_rst_right");
    apply_stimulus_release(4'b1000, "rel_pre_rst");
    m_cur = m_pd;
    m_pv  = 1'b0;
    is_listening = 1'b1;
    wait_cycles(3);
    check_output("rst_win_right", obs_onehot(), 32'd8);
    btn[0] = 1'b1;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    m_cur  = 3;
    m_pd   = 3;
    m_pv   = 1'b0;
    m_held = '0;
    check_quiet("rst_mid_present");
    rst          = 1'b0;
    is_listening = 1'b0;
    wait_cycles(100);
    check_quiet("held_after_rst_early");
    wait_cycles(HOLD - 100);
    model_press(4'b0001);
    check_quiet("held_after_rst_late");
    apply_stimulus_release(4'b0001, "rel_after_rst");

    // Random press/release/window steps.
    for (int n = 0; n < 24; n++) begin
      action = $urandom_range(0, 3);
      if (action == 1 && m_held != '0) begin
        mask = m_held & 4'($urandom_range(0, 15));
        if (mask == '0) mask = m_held;
        apply_stimulus_release(mask, "rnd_release");
      end else if (action >= 2) begin
        apply_stimulus_window($urandom_range(4, 30), "rnd_window");
      end else begin
        mask = 4'($urandom_range(1, 15));
        apply_stimulus_press(mask, $urandom_range(0, 5), "rnd_press");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
